// File: rtl/umul_stream_ctrl_pkg.sv
// Shared types and helpers for the unary-multiplier stream controller.
//   umul_state_t : controller FSM states
//   cw_of()      : width of a count that must hold 0..stream_len inclusive
package umul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } umul_state_t;

  // One bit more than log2 so that an all-ones stream (count == stream_len)
  // does not wrap to zero.
  function automatic int cw_of(input int stream_len);
    return $clog2(stream_len) + 1;
  endfunction

endpackage

// File: rtl/umul_stream_ctrl_if.sv
// Bundle of every non-clock signal between the stream controller and its
// surroundings (operand source, multiplier, Sobol RNG, result consumer).
//   slave  : view taken by umul_stream_ctrl
//   master : view taken by the environment driving the controller
// Signal names keep the controller's point of view (i* into it, o* out of it).
interface umul_stream_ctrl_if #(
  parameter int BITWIDTH   = 8,
  parameter int STREAM_LEN = 256
);
  import umul_pkg::*;

  localparam int CW = cw_of(STREAM_LEN);

  // operand request
  logic                iValid;
  logic                oReady;
  logic [BITWIDTH-1:0] iA;
  logic [BITWIDTH-1:0] iB;
  // multiplier / RNG side
  logic [BITWIDTH-1:0] oB;
  logic                oLoadB;
  logic                oClr;
  logic                oRngEn;
  logic [BITWIDTH-1:0] iSobol;
  logic                oA;
  logic                iMult;
  // result
  logic                oValid;
  logic                iReady;
  logic [CW-1:0]       oResult;

  modport slave (
    input  iValid, iA, iB, iSobol, iMult, iReady,
    output oReady, oB, oLoadB, oClr, oRngEn, oA, oValid, oResult
  );

  modport master (
    output iValid, iA, iB, iSobol, iMult, iReady,
    input  oReady, oB, oLoadB, oClr, oRngEn, oA, oValid, oResult
  );

endinterface

// File: rtl/umul_stream_ctrl_bit_counter.sv
// CW-bit ones counter used as the product accumulator.
//   iClk, iRst : clock, asynchronous active-high reset
//   iClr       : synchronous clear (wins over counting)
//   iEn        : counting window
//   iInc       : bit to add while the window is open
//   oNext      : value the counter takes at the next edge; lets the owner
//                capture the final sum on the same edge as the last add
module umul_bit_counter #(
  parameter int CW = 9
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iClr,
  input  logic          iEn,
  input  logic          iInc,
  output logic [CW-1:0] oNext
);

  logic [CW-1:0] count_q;

  always_comb begin
    oNext = count_q;
    if (iClr) begin
      oNext = '0;
    end else if (iEn && iInc) begin
      oNext = count_q + CW'(1);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      count_q <= '0;
    end else begin
      count_q <= oNext;
    end
  end

endmodule

// File: rtl/umul_stream_ctrl.sv
// Sequencing controller for one unary stochastic multiplier and its Sobol RNG.
// Accepts an operand pair, loads B into the multiplier, clears and runs the
// RNG while streaming A as a unary bitstream (A > Sobol) for STREAM_LEN
// cycles, counts the 1s coming back from the multiplier MUL_LAT cycles later
// and returns that count.
//   iClk, iRst : clock, asynchronous active-high reset
//   bus        : operand handshake (iValid/oReady/iA/iB), multiplier and RNG
//                controls (oB/oLoadB/oClr/oRngEn/iSobol/oA/iMult) and result
//                handshake (oValid/iReady/oResult)
module umul_stream_ctrl #(
  parameter int BITWIDTH   = 8,
  parameter int STREAM_LEN = 256,
  parameter int MUL_LAT    = 1
) (
  input logic               iClk,
  input logic               iRst,
  umul_stream_ctrl_if.slave bus
);
  import umul_pkg::*;

  localparam int CW = cw_of(STREAM_LEN);

  umul_state_t         state_q, state_d;
  logic                ready_q;
  logic [BITWIDTH-1:0] a_q;
  logic [BITWIDTH-1:0] b_q;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [CW-1:0]       res_q;
  logic                accept;
  logic                load_b, clr, rng_en, run_now;
  logic                acc_flag;
  logic [CW-1:0]       acc_next;

  assign accept = ready_q && bus.iValid;

  // Next-state and strobe decode. The cycle counter is shared between the
  // RUN length and the DRAIN length; it is zeroed on every state change.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    load_b  = 1'b0;
    clr     = 1'b0;
    rng_en  = 1'b0;
    run_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        load_b  = 1'b1;
        clr     = 1'b1;
        cyc_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        rng_en  = 1'b1;
        run_now = 1'b1;
        cyc_d   = cyc_q + CW'(1);
        if (cyc_q == CW'(STREAM_LEN - 1)) begin
          cyc_d   = '0;
          state_d = (MUL_LAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == CW'(MUL_LAT - 1)) begin
          cyc_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and result registers. oReady is registered from the next
  // state, so it is high exactly while the FSM sits in IDLE and a new request
  // can only be taken the cycle after the result handshake.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      cyc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      cyc_q   <= cyc_d;
      if (accept) begin
        a_q <= bus.iA;
        b_q <= bus.iB;
      end
      // The last sample is added on the same edge that enters DONE, so the
      // result is taken from the counter's next value.
      if (state_d == DONE && state_q != DONE) begin
        res_q <= acc_next;
      end
    end
  end

  // Delay line aligning the RUN window with the multiplier output latency.
  generate
    if (MUL_LAT == 0) begin : g_no_dly
      assign acc_flag = run_now;
    end else begin : g_dly
      logic [MUL_LAT-1:0] run_p;
      always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
          run_p <= '0;
        end else begin
          run_p[0] <= run_now;
          for (int i = 1; i < MUL_LAT; i++) begin
            run_p[i] <= run_p[i-1];
          end
        end
      end
      assign acc_flag = run_p[MUL_LAT-1];
    end
  endgenerate

  // Accumulator stage: counts iMult while the delayed window is open.
  umul_bit_counter #(
    .CW (CW)
  ) u_counter (
    .iClk  (iClk),
    .iRst  (iRst),
    .iClr  (accept),
    .iEn   (acc_flag),
    .iInc  (bus.iMult),
    .oNext (acc_next)
  );

  assign bus.oReady  = ready_q;
  assign bus.oB      = b_q;
  assign bus.oLoadB  = load_b;
  assign bus.oClr    = clr;
  assign bus.oRngEn  = rng_en;
  assign bus.oA      = (state_q == RUN) && (a_q > bus.iSobol);
  assign bus.oValid  = (state_q == DONE);
  assign bus.oResult = res_q;

endmodule

// File: tb/tb_umul_stream_ctrl.sv
// Bench for umul_stream_ctrl: a behavioural Sobol RNG and a latency-1
// multiplier stub (full-scale B, so iMult is oA one cycle late) around the
// main instance, plus a MUL_LAT=3 instance with iMult tied high.
module tb_umul_stream_ctrl;

  localparam int BW = 8;
  localparam int SL = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  umul_stream_ctrl_if #(.BITWIDTH(BW), .STREAM_LEN(SL)) bus ();
  umul_stream_ctrl_if #(.BITWIDTH(BW), .STREAM_LEN(SL)) bus3 ();

  umul_stream_ctrl #(.BITWIDTH(BW), .STREAM_LEN(SL), .MUL_LAT(1)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  umul_stream_ctrl #(.BITWIDTH(BW), .STREAM_LEN(SL), .MUL_LAT(3)) dut3 (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus3)
  );

  // Sobol sequence, first dimension, Gray-code order: each step flips the
  // direction bit selected by the lowest zero bit of the step index.
  logic [BW-1:0] sob, sidx;

  function automatic logic [BW-1:0] dirv(input logic [BW-1:0] idx);
    for (int c = 0; c < BW; c++) begin
      if (!idx[c]) return BW'(1) << (BW - 1 - c);
    end
    return '0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sob  <= '0;
      sidx <= '0;
    end else if (bus.oClr) begin
      sob  <= '0;
      sidx <= '0;
    end else if (bus.oRngEn) begin
      sob  <= sob ^ dirv(sidx);
      sidx <= sidx + 1'b1;
    end
  end

  logic mult_q = 1'b0;
  logic tie1   = 1'b0;
  always @(posedge clk) mult_q <= bus.oA;

  assign bus.iSobol  = sob;
  assign bus.iMult   = tie1 ? 1'b1 : mult_q;
  assign bus3.iSobol = '0;
  assign bus3.iMult  = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ideal product of a unary A stream against a full-scale B: A/2^BW of the
  // STREAM_LEN samples are 1.
  function automatic int ideal(input logic [BW-1:0] a);
    return (int'(a) * SL) >> BW;
  endfunction

  // Present one request (entered on a negedge), follow it to oValid and check
  // latency, result, the single LOAD cycle and the loaded B.
  task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input int exp_res, input int exp_lat, input string tag);
    int       w, k, loads;
    logic     saw_a;
    logic [BW-1:0] lb;
    bus.iA     = a;
    bus.iB     = b;
    bus.iValid = 1'b1;
    w = 0;
    while (!bus.oReady && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".accept_timeout"}, 32'(w < 2000), 32'd1);
    @(negedge clk);
    bus.iValid = 1'b0;
    bus.iA     = BW'($urandom);
    bus.iB     = BW'($urandom);
    k = 0; loads = 0; saw_a = 1'b0; lb = '0;
    while (!bus.oValid && k < 2000) begin
      if (bus.oA) saw_a = 1'b1;
      if (bus.oLoadB && bus.oClr && !bus.oRngEn) begin
        loads++;
        lb = bus.oB;
      end
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, 32'(k), 32'(exp_lat));
    check({tag, ".result"}, 32'(bus.oResult), 32'(exp_res));
    check({tag, ".load_cycles"}, 32'(loads), 32'd1);
    check({tag, ".loaded_b"}, 32'(lb), 32'(b));
    if (a == 0) check({tag, ".oA_zero"}, 32'(saw_a), 32'd0);
  endtask

  initial begin : stim
    logic [BW-1:0] a, b, a2, b2;
    logic [8:0]    held_res;
    int            bad, k;

    bus.iValid  = 1'b0; bus.iA  = '0; bus.iB  = '0; bus.iReady  = 1'b1;
    bus3.iValid = 1'b0; bus3.iA = '0; bus3.iB = '0; bus3.iReady = 1'b1;

    // reset state
    @(negedge clk);
    check("rst.oReady",  32'(bus.oReady),  32'd1);
    check("rst.oValid",  32'(bus.oValid),  32'd0);
    check("rst.oB",      32'(bus.oB),      32'd0);
    check("rst.oResult", 32'(bus.oResult), 32'd0);
    check("rst.strobes", 32'({bus.oLoadB, bus.oClr, bus.oRngEn, bus.oA}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed ideal-model points
    run_op(8'd200, 8'd255, ideal(8'd200), 258, "a200");
    run_op(8'd0,   8'd255, ideal(8'd0),   258, "a0");
    run_op(8'd255, 8'd255, ideal(8'd255), 258, "a255");

    // randomized operands
    for (int i = 0; i < 5; i++) begin
      a = BW'($urandom);
      b = BW'($urandom);
      run_op(a, b, ideal(a), 258, "rand");
    end

    // iMult stuck high: full window of SL samples, no wrap
    tie1 = 1'b1;
    run_op(BW'($urandom), BW'($urandom), SL, 258, "ones_lat1");
    tie1 = 1'b0;

    // back-to-back
    run_op(8'd128, 8'd255, ideal(8'd128), 258, "b2b0");
    run_op(8'd32,  8'd255, ideal(8'd32),  258, "b2b1");
    @(negedge clk);

    // backpressure with a request held during the busy period
    bus.iReady = 1'b0;
    a  = BW'($urandom);
    a2 = BW'($urandom);
    b2 = BW'($urandom);
    run_op(a, BW'($urandom), ideal(a), 258, "bp");
    held_res   = bus.oResult;
    bus.iValid = 1'b1;
    bus.iA     = a2;
    bus.iB     = b2;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.oValid || bus.oReady || bus.oResult !== held_res) bad++;
    end
    check("bp.stable_cycles_bad", 32'(bad), 32'd0);
    check("bp.held_result", 32'(held_res), 32'(ideal(a)));
    bus.iReady = 1'b1;
    @(negedge clk);
    check("bp.release_oValid", 32'(bus.oValid), 32'd0);
    check("bp.release_oReady", 32'(bus.oReady), 32'd1);
    run_op(a2, b2, ideal(a2), 258, "bp_held");

    // reset in the middle of RUN
    @(negedge clk);
    bus.iA = BW'($urandom); bus.iB = BW'($urandom); bus.iValid = 1'b1;
    k = 0;
    while (!bus.oReady && k < 2000) begin @(negedge clk); k++; end
    @(negedge clk);
    bus.iValid = 1'b0;
    repeat (101) @(negedge clk);
    check("abort.in_run", 32'(bus.oRngEn), 32'd1);
    rst = 1'b1;
    #1;
    check("abort.oValid", 32'(bus.oValid), 32'd0);
    check("abort.oRngEn", 32'(bus.oRngEn), 32'd0);
    check("abort.oA",     32'(bus.oA),     32'd0);
    check("abort.oReady", 32'(bus.oReady), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort.post_oReady",  32'(bus.oReady),  32'd1);
    check("abort.post_oResult", 32'(bus.oResult), 32'd0);
    run_op(8'd64, 8'd255, ideal(8'd64), 258, "after_abort");

    // MUL_LAT=3 instance: window still SL samples, latency 1+SL+3
    @(negedge clk);
    bus3.iA = BW'($urandom); bus3.iB = BW'($urandom); bus3.iValid = 1'b1;
    k = 0;
    while (!bus3.oReady && k < 2000) begin @(negedge clk); k++; end
    @(negedge clk);
    bus3.iValid = 1'b0;
    k = 0;
    while (!bus3.oValid && k < 2000) begin @(negedge clk); k++; end
    check("lat3.latency", 32'(k), 32'(1 + SL + 3));
    check("lat3.result",  32'(bus3.oResult), 32'(SL));
    @(negedge clk);
    check("lat3.handshake_oValid", 32'(bus3.oValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
